// File: rtl/otter_dmem_align_ctrl.sv
// otter_dmem_align_ctrl: data-port sequencer that splits word-crossing loads/stores.
// Build option: define MISALIGN_TRAP_EN to reject crossing accesses instead of splitting.
module otter_dmem_align_ctrl #(
    parameter logic [31:0] IO_BASE   = 32'h11000000,
    parameter logic [31:0] MEM_BYTES = 32'd65536
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGN,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [2:0] {IDLE, RD_LO, CAP, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP, WR_B, RESP} state_t;
`endif

    state_t      r_state;
    logic        r_ready;
    logic        r_we;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_din;
    logic        r_mem_write;
    logic        r_mem_read;
    logic [1:0]  r_mem_size;
    logic        r_mem_sign;

    logic        w_cross;
    logic        w_err;
    logic [31:0] w_a0;

`ifndef MISALIGN_TRAP_EN
    logic        r_split;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [2:0]  r_cnt;
    logic [31:0] r_wdata;
    logic [31:0] r_lo;
    logic        w_oob;
    logic [2:0]  w_nbytes;
    logic [31:0] w_wsh;

    // Shift the {hi,lo} pair down to the requested byte, then size/extend it
    function automatic logic [31:0] f_merge(
        input logic [31:0] hi,
        input logic [31:0] lo,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [63:0] s;
        s = {hi, lo} >> {off, 3'b000};
        if (size == 2'd1)
            return {{16{~uns & s[15]}}, s[15:0]};
        return s[31:0];
    endfunction
`endif

    // Classify the incoming request: crossing, out of range, illegal size
    always_comb begin
        w_a0    = {REQ_ADDR[31:2], 2'b00};
        w_cross = (REQ_ADDR < IO_BASE) &&
                  ((REQ_SIZE == 2'd1 && REQ_ADDR[1:0] == 2'd3) ||
                   (REQ_SIZE == 2'd2 && REQ_ADDR[1:0] != 2'd0));
`ifdef MISALIGN_TRAP_EN
        w_err   = (REQ_SIZE == 2'd3) || w_cross;
`else
        w_oob    = (w_a0 + 32'd4) >= MEM_BYTES;
        w_err    = (REQ_SIZE == 2'd3) || (w_cross && w_oob);
        w_nbytes = (r_size == 2'd1) ? 3'd2 : 3'd4;
        w_wsh    = r_wdata >> {r_cnt[1:0], 3'b000};
`endif
    end

    // Request sequencer with registered memory and response outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_din   <= 32'h0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_size  <= 2'd0;
            r_mem_sign  <= 1'b0;
`ifndef MISALIGN_TRAP_EN
            r_split     <= 1'b0;
            r_off       <= 2'd0;
            r_size      <= 2'd0;
            r_sign      <= 1'b0;
            r_cnt       <= 3'd0;
            r_wdata     <= 32'h0;
            r_lo        <= 32'h0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (REQ_VALID && r_ready) begin
                        r_ready <= 1'b0;
                        r_we    <= REQ_WE;
`ifndef MISALIGN_TRAP_EN
                        r_off   <= REQ_ADDR[1:0];
                        r_size  <= REQ_SIZE;
                        r_sign  <= REQ_SIGN;
                        r_wdata <= REQ_WDATA;
                        r_split <= 1'b0;
`endif
                        if (w_err) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
`ifndef MISALIGN_TRAP_EN
                        end else if (w_cross && !REQ_WE) begin
                            r_state    <= RD_LO;
                            r_split    <= 1'b1;
                            r_mem_addr <= w_a0;
                            r_mem_size <= 2'd2;
                            r_mem_sign <= 1'b0;
                            r_mem_read <= 1'b1;
                        end else if (w_cross) begin
                            r_state     <= WR_B;
                            r_split     <= 1'b1;
                            r_cnt       <= 3'd1;
                            r_mem_addr  <= REQ_ADDR;
                            r_mem_size  <= 2'd0;
                            r_mem_sign  <= 1'b0;
                            r_mem_din   <= {24'h0, REQ_WDATA[7:0]};
                            r_mem_write <= 1'b1;
`endif
                        end else begin
                            r_state     <= REQ_WE ? CAP : RD_LO;
                            r_mem_addr  <= REQ_ADDR;
                            r_mem_size  <= REQ_SIZE;
                            r_mem_sign  <= REQ_SIGN;
                            r_mem_din   <= REQ_WDATA;
                            r_mem_write <= REQ_WE;
                            r_mem_read  <= !REQ_WE;
                        end
                    end
                end
                RD_LO: begin
`ifndef MISALIGN_TRAP_EN
                    if (r_split) begin
                        r_state    <= RD_HI;
                        r_mem_addr <= r_mem_addr + 32'd4;
                        r_mem_read <= 1'b1;
                    end else begin
                        r_state    <= CAP;
                        r_mem_read <= 1'b0;
                    end
`else
                    r_state    <= CAP;
                    r_mem_read <= 1'b0;
`endif
                end
`ifndef MISALIGN_TRAP_EN
                RD_HI: begin
                    r_lo       <= MEM_DOUT2;
                    r_mem_read <= 1'b0;
                    r_state    <= CAP;
                end
                WR_B: begin
                    if (r_cnt == w_nbytes) begin
                        r_mem_write <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                        r_state     <= RESP;
                    end else begin
                        r_mem_addr  <= r_mem_addr + 32'd1;
                        r_mem_din   <= {24'h0, w_wsh[7:0]};
                        r_mem_write <= 1'b1;
                        r_cnt       <= r_cnt + 3'd1;
                    end
                end
`endif
                CAP: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_state     <= RESP;
`ifndef MISALIGN_TRAP_EN
                    if (r_we)
                        r_rsp_rdata <= 32'h0;
                    else if (r_split)
                        r_rsp_rdata <= f_merge(MEM_DOUT2, r_lo, r_off,
                                               r_size, r_sign);
                    else
                        r_rsp_rdata <= MEM_DOUT2;
`else
                    r_rsp_rdata <= r_we ? 32'h0 : MEM_DOUT2;
`endif
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                    r_ready     <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign REQ_READY  = r_ready;
    assign RSP_VALID  = r_rsp_valid;
    assign RSP_RDATA  = r_rsp_rdata;
    assign RSP_ERR    = r_rsp_err;
    assign MEM_ADDR2  = r_mem_addr;
    assign MEM_DIN2   = r_mem_din;
    assign MEM_WRITE2 = r_mem_write;
    assign MEM_READ2  = r_mem_read;
    assign MEM_SIZE   = r_mem_size;
    assign MEM_SIGN   = r_mem_sign;

endmodule

// File: tb/tb_otter_dmem_align_ctrl.sv
// tb_otter_dmem_align_ctrl: directed bench with a byte-addressed memory model.
// Expected values are hand-computed from the access patterns below.
module tb_otter_dmem_align_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WE = 1'b0;
    logic [31:0] REQ_ADDR = 32'h0;
    logic [31:0] REQ_WDATA = 32'h0;
    logic [1:0]  REQ_SIZE = 2'd0;
    logic        REQ_SIGN = 1'b0;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic        MEM_WRITE2;
    logic        MEM_READ2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] MMIO_WORD = 32'h12345678;

    logic [7:0]  mem [0:65535];
    logic [31:0] r_word = 32'h0;
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = 16'h0;
    logic [31:0] bd_data = 32'h0;
    logic [15:0] w_b;
    logic [15:0] w_a;
    logic [31:0] d_sh;
    logic [7:0]  exp_b [4];

    otter_dmem_align_ctrl dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WE    (REQ_WE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .REQ_SIZE  (REQ_SIZE),
        .REQ_SIGN  (REQ_SIGN),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .MEM_ADDR2 (MEM_ADDR2),
        .MEM_DIN2  (MEM_DIN2),
        .MEM_WRITE2(MEM_WRITE2),
        .MEM_READ2 (MEM_READ2),
        .MEM_SIZE  (MEM_SIZE),
        .MEM_SIGN  (MEM_SIGN),
        .MEM_DOUT2 (MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    assign w_b  = MEM_ADDR2[15:0];
    assign w_a  = {MEM_ADDR2[15:2], 2'b00};
    assign d_sh = r_word >> {MEM_ADDR2[1:0], 3'b000};

    // Memory model: synchronous word read, byte-lane writes, backdoor preload
    always @(posedge CLK) begin
        if (bd_we) begin
            mem[bd_addr]         <= bd_data[7:0];
            mem[bd_addr + 16'd1] <= bd_data[15:8];
            mem[bd_addr + 16'd2] <= bd_data[23:16];
            mem[bd_addr + 16'd3] <= bd_data[31:24];
        end else if (MEM_WRITE2 && MEM_ADDR2 < 32'h11000000) begin
            mem[w_b] <= MEM_DIN2[7:0];
            if (MEM_SIZE != 2'd0)
                mem[w_b + 16'd1] <= MEM_DIN2[15:8];
            if (MEM_SIZE == 2'd2) begin
                mem[w_b + 16'd2] <= MEM_DIN2[23:16];
                mem[w_b + 16'd3] <= MEM_DIN2[31:24];
            end
        end
        if (MEM_READ2)
            r_word <= (MEM_ADDR2 >= 32'h11000000) ? MMIO_WORD :
                      {mem[w_a + 16'd3], mem[w_a + 16'd2],
                       mem[w_a + 16'd1], mem[w_a]};
    end

    // Read data is formatted from the current address, size and sign
    always_comb begin
        MEM_DOUT2 = d_sh;
        if (MEM_SIZE == 2'd0)
            MEM_DOUT2 = {{24{~MEM_SIGN & d_sh[7]}}, d_sh[7:0]};
        else if (MEM_SIZE == 2'd1)
            MEM_DOUT2 = {{16{~MEM_SIGN & d_sh[15]}}, d_sh[15:0]};
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic req(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz,
                       input logic sg);
        chk1("ready_before_req", REQ_READY, 1'b1);
        REQ_WE    = we;
        REQ_ADDR  = a;
        REQ_WDATA = d;
        REQ_SIZE  = sz;
        REQ_SIGN  = sg;
        REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
    endtask

    task automatic rsp(input string tag, input logic [31:0] rd,
                       input logic err);
        chk1({tag, "_valid"}, RSP_VALID, 1'b1);
        chk({tag, "_rdata"}, RSP_RDATA, rd);
        chk1({tag, "_err"}, RSP_ERR, err);
    endtask

    initial begin
        exp_b = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
        tick();
        tick();
        chk1("rst_ready", REQ_READY, 1'b1);
        chk1("rst_rsp", RSP_VALID, 1'b0);
        chk1("rst_rd", MEM_READ2, 1'b0);
        chk1("rst_wr", MEM_WRITE2, 1'b0);
        chk("rst_addr", MEM_ADDR2, 32'h0);
        chk("rst_rdata", RSP_RDATA, 32'h0);
        RST_N = 1'b1;
        tick();

        poke(16'h100, 32'hDEADBEEF);
        req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        chk1("lw_c1_rd", MEM_READ2, 1'b1);
        chk("lw_c1_addr", MEM_ADDR2, 32'h100);
        chk1("lw_c1_ready", REQ_READY, 1'b0);
        tick();
        chk1("lw_c2_rd", MEM_READ2, 1'b0);
        chk1("lw_c2_rsp", RSP_VALID, 1'b0);
        tick();
        rsp("lw_c3", 32'hDEADBEEF, 1'b0);
        tick();
        chk1("lw_c4_rsp", RSP_VALID, 1'b0);
        chk1("lw_c4_ready", REQ_READY, 1'b1);

        poke(16'h100, 32'h44332211);
        poke(16'h104, 32'h88776655);
        req(1'b0, 32'h102, 32'h0, 2'd2, 1'b0);
        chk1("xlw_c1_rd", MEM_READ2, 1'b1);
        chk("xlw_c1_addr", MEM_ADDR2, 32'h100);
        chk("xlw_c1_size", 32'(MEM_SIZE), 32'd2);
        tick();
        chk1("xlw_c2_rd", MEM_READ2, 1'b1);
        chk("xlw_c2_addr", MEM_ADDR2, 32'h104);
        chk("xlw_c2_size", 32'(MEM_SIZE), 32'd2);
        tick();
        chk1("xlw_c3_rd", MEM_READ2, 1'b0);
        chk1("xlw_c3_rsp", RSP_VALID, 1'b0);
        tick();
        rsp("xlw_c4", 32'h66554433, 1'b0);
        tick();

        poke(16'h100, 32'h80332211);
        poke(16'h104, 32'h000000F5);
        req(1'b0, 32'h103, 32'h0, 2'd1, 1'b0);
        tick();
        tick();
        tick();
        rsp("xlh", 32'hFFFFF580, 1'b0);
        tick();
        req(1'b0, 32'h103, 32'h0, 2'd1, 1'b1);
        tick();
        tick();
        tick();
        rsp("xlhu", 32'h0000F580, 1'b0);
        tick();

        poke(16'h200, 32'h0);
        poke(16'h204, 32'h0);
        req(1'b1, 32'h201, 32'h0A0B0C0D, 2'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk1("xsw_wr", MEM_WRITE2, 1'b1);
            chk("xsw_addr", MEM_ADDR2, 32'h201 + 32'(k));
            chk("xsw_size", 32'(MEM_SIZE), 32'd0);
            chk("xsw_din", 32'(MEM_DIN2[7:0]), 32'(exp_b[k]));
            chk1("xsw_rsp_early", RSP_VALID, 1'b0);
            tick();
        end
        chk1("xsw_c5_wr", MEM_WRITE2, 1'b0);
        rsp("xsw_c5", 32'h0, 1'b0);
        tick();
        req(1'b0, 32'h200, 32'h0, 2'd2, 1'b0);
        tick();
        tick();
        rsp("lw_after_xsw", 32'h0B0C0D00, 1'b0);
        tick();

        req(1'b1, 32'h208, 32'h1234ABCD, 2'd2, 1'b0);
        chk1("sw_c1_wr", MEM_WRITE2, 1'b1);
        chk("sw_c1_din", MEM_DIN2, 32'h1234ABCD);
        chk("sw_c1_size", 32'(MEM_SIZE), 32'd2);
        tick();
        chk1("sw_c2_wr", MEM_WRITE2, 1'b0);
        rsp("sw_c2", 32'h0, 1'b0);
        tick();

        req(1'b0, 32'h40, 32'h0, 2'd3, 1'b0);
        rsp("size3_c1", 32'h0, 1'b1);
        chk1("size3_rd", MEM_READ2, 1'b0);
        chk1("size3_wr", MEM_WRITE2, 1'b0);
        tick();
        chk1("size3_c2_rsp", RSP_VALID, 1'b0);
        chk1("size3_c2_ready", REQ_READY, 1'b1);

        req(1'b0, 32'hFFFE, 32'h0, 2'd2, 1'b0);
        rsp("oob_c1", 32'h0, 1'b1);
        chk1("oob_rd", MEM_READ2, 1'b0);
        chk1("oob_wr", MEM_WRITE2, 1'b0);
        tick();
        chk1("oob_c2_rd", MEM_READ2, 1'b0);

        req(1'b0, 32'h11000002, 32'h0, 2'd1, 1'b0);
        chk1("mmio_c1_rd", MEM_READ2, 1'b1);
        chk("mmio_c1_addr", MEM_ADDR2, 32'h11000002);
        chk("mmio_c1_size", 32'(MEM_SIZE), 32'd1);
        tick();
        chk1("mmio_c2_rd", MEM_READ2, 1'b0);
        tick();
        rsp("mmio_c3", 32'h00001234, 1'b0);
        tick();

        poke(16'h300, 32'h0);
        poke(16'h304, 32'h0);
        req(1'b1, 32'h301, 32'h11223344, 2'd2, 1'b0);
        chk("rstx_c1_addr", MEM_ADDR2, 32'h301);
        tick();
        chk1("rstx_c2_wr", MEM_WRITE2, 1'b1);
        chk("rstx_c2_addr", MEM_ADDR2, 32'h302);
        #1;
        RST_N = 1'b0;
        #1;
        chk1("rstx_wr_drop", MEM_WRITE2, 1'b0);
        chk1("rstx_rd_drop", MEM_READ2, 1'b0);
        chk1("rstx_rsp", RSP_VALID, 1'b0);
        chk1("rstx_ready", REQ_READY, 1'b1);
        tick();
        tick();
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("rstx_no_rsp", RSP_VALID, 1'b0);
            chk1("rstx_no_wr", MEM_WRITE2, 1'b0);
        end
        req(1'b0, 32'h300, 32'h0, 2'd2, 1'b0);
        tick();
        tick();
        rsp("rstx_mem", 32'h00004400, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/otter_dmem_align_ctrl.md
Name: otter_dmem_align_ctrl

Overview:
Sequencer between the OTTER core's data-access stage and data port 2 of the byte-addressable dual-port memory. The memory port handles any access inside one 32-bit word but not accesses that span two words. This block takes one load/store request at a time and passes it through when it fits in one word. A spanning load becomes two aligned word reads that are merged here; a spanning store becomes a sequence of byte stores. It also flags illegal sizes and out-of-range accesses, and returns one response per request.

Parameters:
IO_BASE, 32'h11000000, addresses >= this are MMIO: always single pass-through, never split
MEM_BYTES, 65536, size of memory space in bytes; a split access touching byte >= MEM_BYTES (below IO_BASE) is an error

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  request present
REQ_READY  out  1  block can accept (high only in IDLE)
REQ_WE  in  1  1=store, 0=load
REQ_ADDR  in  32  byte address
REQ_WDATA  in  32  store data, LSB-aligned
REQ_SIZE  in  2  0=byte, 1=half, 2=word, 3=illegal
REQ_SIGN  in  1  1=unsigned load (lbu/lhu)
RSP_VALID  out  1  one-cycle response pulse
RSP_RDATA  out  32  load result, extended; 0 for stores and errors
RSP_ERR  out  1  request rejected, no memory side effect
MEM_ADDR2  out  32  memory port-2 address
MEM_DIN2  out  32  memory write data
MEM_WRITE2  out  1  memory write strobe
MEM_READ2  out  1  memory read strobe
MEM_SIZE  out  2  memory access size
MEM_SIGN  out  1  memory unsigned flag
MEM_DOUT2  in  32  memory read data, valid the cycle after MEM_READ2; depends combinationally on MEM_ADDR2, MEM_SIZE and MEM_SIGN

Behaviour:
- Reset: all outputs are 0 except REQ_READY=1; state=IDLE. Reset is asynchronous and may arrive mid-sequence. Any byte stores already issued remain in memory; no further strobes are issued.
- Accept happens when REQ_VALID && REQ_READY in IDLE; the request is registered. Cycle numbering below starts at the accept cycle = 0.
- Crossing is defined as: size1 with addr[1:0]==3, or size2 with addr[1:0]!=0. Addresses >= IO_BASE are never crossing.
- States: IDLE, RD_LO, RD_HI, CAP, WR_B, RESP.
- REQ_SIZE==3: IDLE->RESP. RSP_VALID=1 and RSP_ERR=1 in cycle 1. No memory strobe.
- Crossing access with the high word >= MEM_BYTES: same as REQ_SIZE==3 (RSP_ERR=1 in cycle 1, no strobe).
- Single load: cycle 1 drives MEM_READ2=1 with the request's addr, size and sign. Cycle 2 holds addr, size and sign with strobe=0 and captures MEM_DOUT2. Cycle 3 drives RSP_VALID with the captured data.
- Single store: cycle 1 drives MEM_WRITE2=1 with addr, size and DIN=REQ_WDATA. Cycle 2 drives RSP_VALID with RSP_RDATA=0.
- Crossing load: A0=addr&~3.
  - Cycle 1: read A0, size2, sign0.
  - Cycle 2: read A0+4, and capture the low word.
  - Cycle 3: capture the high word.
  - Cycle 4: RSP. Result = ({hi,lo} >> 8*addr[1:0]) truncated to 16 or 32 bits. A half-word is sign-extended unless REQ_SIGN=1.
- Crossing store: N=2 for a half, N=4 for a word. Cycles 1..N issue a byte store (size0) at addr+k with MEM_DIN2[7:0]=REQ_WDATA byte k, k=0..N-1. Cycle N+1 is RSP.
- Strobes are high for exactly one cycle per issued access. RSP_VALID is high for exactly one cycle per accepted request. REQ_READY=0 from cycle 1 through the RSP cycle and returns to 1 the cycle after RSP.
- MMIO stores pass straight through; the memory itself raises IO_WR.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: crossing accesses are not split. They take the error path (RSP_ERR=1 in cycle 1, no strobe). States RD_HI and WR_B are removed.
- Undefined: splitting is performed as described in Behaviour.

Test Plan:
- lw 0x100, mem[0x100]=0xDEADBEEF -> MEM_READ2 in cycle 1 only; cycle 3 RSP_VALID, RDATA=0xDEADBEEF, ERR=0.
- lw 0x102, mem[0x100]=0x44332211, mem[0x104]=0x88776655 -> reads at 0x100 then 0x104, both size2; cycle 4 RDATA=0x66554433.
- lh 0x103, mem[0x100]=0x80332211, mem[0x104]=0x000000F5 -> RDATA=0xFFFFF580; the same access as lhu -> 0x0000F580.
- sw 0x0A0B0C0D at 0x201 -> byte stores at 0x201/0x202/0x203/0x204 with DIN[7:0]=0D/0C/0B/0A in cycles 1-4, RSP in cycle 5. A following lw 0x200 with prior mem[0x200]=0 -> 0x0B0C0D00.
- REQ_SIZE=3 at 0x40, and a crossing lw at 0xFFFE with MEM_BYTES=65536 -> cycle 1 RSP_ERR=1, RDATA=0, no strobes. lh at 0x11000002 -> single read, no split.
- RST_N low in cycle 2 of a split sw at 0x301 -> all strobes drop immediately and RSP_VALID never fires. REQ_READY=1 after release; only byte 0x301 has been written.
